// File: rtl/fib_sequencer.sv
// fib_sequencer: Moore FSM that drives the regfile/ALU datapath to fill r0..r(N-1) with Fibonacci terms.
// Optional: define FIB_CARRY_ABORT_EN to end a sequence right after the first compute write that carries.
module fib_sequencer #(
    parameter int         NUM_REGS   = 16,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] ADD_OP     = 8'b0000_0101,
    parameter logic [7:0] PASS_OP    = 8'b0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(NUM_REGS):0]     term_count,
    input  logic                          alu_carry,
    output logic [NUM_REGS-1:0]           regEnable,
    output logic [$clog2(NUM_REGS)-1:0]   ra_sel,
    output logic [$clog2(NUM_REGS)-1:0]   rb_sel,
    output logic [7:0]                    alu_op,
    output logic                          imm_en,
    output logic [DATA_WIDTH-1:0]         imm,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);

    localparam int IDXW = $clog2(NUM_REGS);
    localparam int CW   = IDXW + 1;
    localparam logic [CW-1:0] NC_MAX = CW'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   nc, nc_n;
    logic [IDXW-1:0] idx, idx_n;
    logic            ovf_n;

    always_comb begin
        state_n = state;
        nc_n    = nc;
        idx_n   = idx;
        ovf_n   = ovf;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nc_n    = (term_count > NC_MAX) ? NC_MAX : term_count;
                    ovf_n   = 1'b0;
                    state_n = (nc_n == '0) ? S_DONE : S_INIT0;
                end
            end
            S_INIT0: begin
                state_n = (nc == CW'(1)) ? S_DONE : S_INIT1;
            end
            S_INIT1: begin
                idx_n   = IDXW'(2);
                state_n = (nc == CW'(2)) ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (alu_carry)
                    ovf_n = 1'b1;
                if ({1'b0, idx} == nc - CW'(1))
                    state_n = S_DONE;
                else
                    idx_n = idx + IDXW'(1);
`ifdef FIB_CARRY_ABORT_EN
                if (alu_carry)
                    state_n = S_DONE;
`endif
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            nc        <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            regEnable <= '0;
            ra_sel    <= '0;
            rb_sel    <= '0;
            alu_op    <= PASS_OP;
            imm_en    <= 1'b0;
            imm       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            nc        <= nc_n;
            idx       <= idx_n;
            ovf       <= ovf_n;
            regEnable <= '0;
            ra_sel    <= '0;
            rb_sel    <= '0;
            alu_op    <= PASS_OP;
            imm_en    <= 1'b0;
            imm       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            case (state_n)
                S_INIT0: begin
                    regEnable <= NUM_REGS'(1);
                    imm_en    <= 1'b1;
                    imm       <= '0;
                    busy      <= 1'b1;
                end
                S_INIT1: begin
                    regEnable <= NUM_REGS'(2);
                    imm_en    <= 1'b1;
                    imm       <= DATA_WIDTH'(1);
                    busy      <= 1'b1;
                end
                S_COMPUTE: begin
                    regEnable <= NUM_REGS'(1) << idx_n;
                    ra_sel    <= idx_n - IDXW'(1);
                    rb_sel    <= idx_n - IDXW'(2);
                    alu_op    <= ADD_OP;
                    busy      <= 1'b1;
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
